uart_rx_cmd: RTL and testbench
==============================

UART_RX_CMD -- requirements
Module: uart_rx_cmd

Interface
REQ-001 Parameter BIT_CNT, default 868, clock cycles per UART bit (100 MHz / 115200 baud).
REQ-002 Parameter SYNC_STAGES, default 2, number of input synchronizer flip-flops on rxd_i.
REQ-003 clk  input  1  system clock, 100 MHz; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rxd_i  input  1  UART receive line (RsRx), idle high, 8N1, LSB first.
REQ-006 clr_i  input  1  synchronous clear; aborts reception in progress.
REQ-007 data_o  output  8  last correctly framed received byte.
REQ-008 data_valid_o  output  1  one-cycle pulse, data_o updated.
REQ-009 frame_err_o  output  1  one-cycle pulse, stop bit sampled low.
REQ-010 busy_o  output  1  high while a frame is being received (state not IDLE).
REQ-011 cmd_sel_o  output  2  result selection (result_sel_t encoding), held.
REQ-012 cmd_sel_update_o  output  1  one-cycle pulse when cmd_sel_o is written.
REQ-013 cmd_dim_up_pls_o / cmd_dim_dwn_pls_o  output  1 each  one-cycle dim pulses.
REQ-014 cmd_uart_en_o  output  1  held UART-report enable requested by PC.

Function
REQ-015 rxd_i SHALL pass through SYNC_STAGES flip-flops, all reset to 1; the FSM uses only the synchronized value.
REQ-016 FSM states SHALL be IDLE, START, DATA, STOP, BREAK.
REQ-017 IDLE: synchronized rxd = 0 -> START, bit counter cleared.
REQ-018 START: at count BIT_CNT/2-1, sample; 1 -> IDLE (glitch, no output); 0 -> DATA, counter cleared.
REQ-019 DATA: every BIT_CNT cycles sample one bit into shift register LSB first; after 8th sample -> STOP.
REQ-020 STOP: after BIT_CNT cycles sample; 1 -> IDLE with data_o loaded and data_valid_o pulsed the next cycle; 0 -> BREAK with frame_err_o pulsed, data_o unchanged.
REQ-021 BREAK: stay until synchronized rxd = 1, then IDLE; no falling-edge detection while in BREAK.
REQ-022 Latency: data_valid_o SHALL rise exactly one clk after the stop-bit sample cycle; sampling points mid-bit (±1 cycle).
REQ-023 Bit counter width SHALL be $clog2(BIT_CNT); counter wraps to 0 at BIT_CNT-1.
REQ-024 Command decode on each data_valid_o byte, outputs in the same cycle as data_valid_o: "0".."3" -> cmd_sel_o = byte[1:0] plus cmd_sel_update_o; "+" -> cmd_dim_up_pls_o; "-" -> cmd_dim_dwn_pls_o; "E"/"e" -> cmd_uart_en_o = 1; "D"/"d" -> cmd_uart_en_o = 0; all other bytes ignored (data_valid_o still pulses).
REQ-025 clr_i = 1 SHALL force IDLE, clear counters and shift register, suppress all pulses that cycle; cmd_sel_o, cmd_uart_en_o, data_o keep their values.
REQ-026 clr_i held high SHALL block reception; a frame starting under clr_i is ignored entirely.
REQ-027 Back-to-back frames (stop bit directly followed by start bit) SHALL be received without loss.

Reset
REQ-028 On rst_n = 0: state IDLE, data_o = 8'h00, all pulses 0, busy_o = 0, cmd_sel_o = 2'b00, cmd_uart_en_o = 0, synchronizer = all 1.
REQ-029 Reset mid-frame SHALL discard the frame; after release the first falling edge starts a new frame.

Structure
REQ-030 mm_pkg SHALL hold uart_rx_state_t, UART_BIT_CNT (shared with transmitter), and ASCII command constants.
REQ-031 Bit-level receiver SHALL be sub-module uart_rx_core (sync, FSM, shift register, data/valid/frame_err); uart_rx_cmd adds the command decoder.

Verification
REQ-032 Send 8'h55 at 115200 baud -> data_o = 8'h55, one data_valid_o pulse, no frame_err_o.
REQ-033 Send "2" then "+" back-to-back -> cmd_sel_o = 2'b10 with cmd_sel_update_o, then one cmd_dim_up_pls_o; two data_valid_o pulses.
REQ-034 Low glitch of 200 cycles on idle line -> returns to IDLE, no pulses, busy_o high only during glitch evaluation.
REQ-035 Frame 8'hA3 with stop bit low, line low 20 bit times -> one frame_err_o, data_o unchanged, next frame "E" received, cmd_uart_en_o = 1.
REQ-036 clr_i pulsed during bit 4 of "1" -> no data_valid_o; following "3" -> cmd_sel_o = 2'b11.
REQ-037 rst_n asserted during DATA of "d" -> all outputs at reset values; next frame 8'h30 -> cmd_sel_o = 2'b00, cmd_sel_update_o pulses.

Source files
------------

// File: rtl/mm_pkg.sv
// Purpose: shared UART receive state, timing and command constants.
// Latency: not applicable; this package holds declarations only.
// Backpressure: not applicable; the receiver has no flow control.
package mm_pkg;

  // Clock cycles per bit at 100 MHz / 115200 baud. The transmitter uses the same value.
  localparam int UART_BIT_CNT = 868;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } uart_rx_state_t;

  // Result selection requested by the PC. The digit '0'..'3' selects the result directly.
  typedef enum logic [1:0] {
    RSEL_0 = 2'd0,
    RSEL_1 = 2'd1,
    RSEL_2 = 2'd2,
    RSEL_3 = 2'd3
  } result_sel_t;

  // ASCII command bytes.
  localparam logic [7:0] ASCII_0     = 8'h30;
  localparam logic [7:0] ASCII_3     = 8'h33;
  localparam logic [7:0] ASCII_PLUS  = 8'h2B;
  localparam logic [7:0] ASCII_MINUS = 8'h2D;
  localparam logic [7:0] ASCII_E_UC  = 8'h45;
  localparam logic [7:0] ASCII_E_LC  = 8'h65;
  localparam logic [7:0] ASCII_D_UC  = 8'h44;
  localparam logic [7:0] ASCII_D_LC  = 8'h64;

  // Returns true for the selection digits '0'..'3'.
  function automatic logic is_sel_digit(input logic [7:0] b);
    return (b >= ASCII_0) && (b <= ASCII_3);
  endfunction

endpackage

// File: rtl/uart_rx_core.sv
// Purpose: bit-level 8N1 UART receiver. It contains the synchronizer, the FSM and the shift register.
// Latency: data_valid_o and frame_err_o rise one clock after the stop-bit sample.
// Backpressure: none. Each byte is presented once and is lost if nobody takes it.
module uart_rx_core
  import mm_pkg::*;
#(
  parameter int BIT_CNT     = UART_BIT_CNT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  input  logic       clr_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic       load_o,
  output logic [7:0] load_byte_o
);

  localparam int CW = (BIT_CNT > 1) ? $clog2(BIT_CNT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(BIT_CNT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(BIT_CNT / 2 - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [SYNC_STAGES-1:0] r_sync;
  uart_rx_state_t         r_state;
  logic [CW-1:0]          r_cnt;
  logic [2:0]             r_bit_idx;
  logic [7:0]             r_shift;
  logic [7:0]             r_data;
  logic                   r_valid;
  logic                   r_ferr;

  logic w_rxd;
  logic w_bit_done;
  logic w_half_done;

  // Shift the asynchronous line through the synchronizer. It resets to idle-high so that reset creates no false start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '1;
    end else begin
      r_sync[0] <= rxd_i;
      for (int i = 1; i < SYNC_STAGES; i++) begin
        r_sync[i] <= r_sync[i-1];
      end
    end
  end

  assign w_rxd       = r_sync[SYNC_STAGES-1];
  assign w_bit_done  = (r_cnt == CNT_LAST);
  assign w_half_done = (r_cnt == CNT_HALF);

  // Load strobe for a good stop bit. The command decoder uses it so that its outputs line up with data_valid_o.
  always_comb begin
    load_o = 1'b0;
    if (!clr_i && (r_state == ST_STOP) && w_bit_done && w_rxd) begin
      load_o = 1'b1;
    end
  end

  assign load_byte_o = r_shift;

  // Receive FSM. It finds the start edge, samples each bit mid-bit, checks the stop bit and waits out break conditions.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_data    <= '0;
      r_valid   <= 1'b0;
      r_ferr    <= 1'b0;
    end else begin
      r_valid <= 1'b0;
      r_ferr  <= 1'b0;
      if (clr_i) begin
        // Abort any frame in progress. r_data keeps the last good byte.
        r_state   <= ST_IDLE;
        r_cnt     <= '0;
        r_bit_idx <= '0;
        r_shift   <= '0;
      end else begin
        case (r_state)
          ST_IDLE: begin
            r_cnt     <= '0;
            r_bit_idx <= '0;
            if (!w_rxd) begin
              r_state <= ST_START;
            end
          end
          ST_START: begin
            if (w_half_done) begin
              r_cnt <= '0;
              // A line that is high again at mid start bit was a glitch.
              r_state <= w_rxd ? ST_IDLE : ST_DATA;
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_DATA: begin
            if (w_bit_done) begin
              r_cnt     <= '0;
              r_shift   <= {w_rxd, r_shift[7:1]};
              r_bit_idx <= r_bit_idx + 3'd1;
              if (r_bit_idx == 3'd7) begin
                r_state <= ST_STOP;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_STOP: begin
            if (w_bit_done) begin
              r_cnt <= '0;
              if (w_rxd) begin
                r_state <= ST_IDLE;
                r_data  <= r_shift;
                r_valid <= 1'b1;
              end else begin
                r_state <= ST_BREAK;
                r_ferr  <= 1'b1;
              end
            end else begin
              r_cnt <= r_cnt + CNT_ONE;
            end
          end
          ST_BREAK: begin
            // A line held low must not be taken as a new start edge until it has gone idle.
            r_cnt <= '0;
            if (w_rxd) begin
              r_state <= ST_IDLE;
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
          end
        endcase
      end
    end
  end

  assign data_o       = r_data;
  assign data_valid_o = r_valid;
  assign frame_err_o  = r_ferr;
  assign busy_o       = (r_state != ST_IDLE);

endmodule

// File: rtl/uart_rx_cmd.sv
// Purpose: UART receiver with an ASCII command decoder for result select, dimming and report enable.
// Latency: command outputs update in the same cycle as data_valid_o, one clock after the stop-bit sample.
// Backpressure: none. Commands take effect immediately, and unknown bytes are dropped.
module uart_rx_cmd
  import mm_pkg::*;
#(
  parameter int BIT_CNT     = UART_BIT_CNT,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rxd_i,
  input  logic       clr_i,
  output logic [7:0] data_o,
  output logic       data_valid_o,
  output logic       frame_err_o,
  output logic       busy_o,
  output logic [1:0] cmd_sel_o,
  output logic       cmd_sel_update_o,
  output logic       cmd_dim_up_pls_o,
  output logic       cmd_dim_dwn_pls_o,
  output logic       cmd_uart_en_o
);

  logic       w_load;
  logic [7:0] w_load_byte;

  result_sel_t r_cmd_sel;
  logic        r_sel_upd;
  logic        r_dim_up;
  logic        r_dim_dwn;
  logic        r_uart_en;

  uart_rx_core #(
    .BIT_CNT     (BIT_CNT),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_core (
    .clk          (clk),
    .rst_n        (rst_n),
    .rxd_i        (rxd_i),
    .clr_i        (clr_i),
    .data_o       (data_o),
    .data_valid_o (data_valid_o),
    .frame_err_o  (frame_err_o),
    .busy_o       (busy_o),
    .load_o       (w_load),
    .load_byte_o  (w_load_byte)
  );

  // Decode the byte on the core's load strobe so that the registered command outputs appear with data_valid_o.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd_sel <= RSEL_0;
      r_sel_upd <= 1'b0;
      r_dim_up  <= 1'b0;
      r_dim_dwn <= 1'b0;
      r_uart_en <= 1'b0;
    end else begin
      r_sel_upd <= 1'b0;
      r_dim_up  <= 1'b0;
      r_dim_dwn <= 1'b0;
      if (w_load) begin
        if (is_sel_digit(w_load_byte)) begin
          r_cmd_sel <= result_sel_t'(w_load_byte[1:0]);
          r_sel_upd <= 1'b1;
        end else if (w_load_byte == ASCII_PLUS) begin
          r_dim_up <= 1'b1;
        end else if (w_load_byte == ASCII_MINUS) begin
          r_dim_dwn <= 1'b1;
        end else if ((w_load_byte == ASCII_E_UC) || (w_load_byte == ASCII_E_LC)) begin
          r_uart_en <= 1'b1;
        end else if ((w_load_byte == ASCII_D_UC) || (w_load_byte == ASCII_D_LC)) begin
          r_uart_en <= 1'b0;
        end
      end
    end
  end

  assign cmd_sel_o         = r_cmd_sel;
  assign cmd_sel_update_o  = r_sel_upd;
  assign cmd_dim_up_pls_o  = r_dim_up;
  assign cmd_dim_dwn_pls_o = r_dim_dwn;
  assign cmd_uart_en_o     = r_uart_en;

endmodule

// File: tb/tb_uart_rx_cmd.sv
// Purpose: directed bench for uart_rx_cmd. It sends 8N1 frames and checks the outputs against hand-computed values.
// Latency: all checks take place after an idle gap, once the frame has settled.
// Backpressure: not applicable.
module tb_uart_rx_cmd;

  localparam int BIT = 16;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rxd;
  logic       clr;
  logic [7:0] data_o;
  logic       data_valid_o;
  logic       frame_err_o;
  logic       busy_o;
  logic [1:0] cmd_sel_o;
  logic       cmd_sel_update_o;
  logic       cmd_dim_up_pls_o;
  logic       cmd_dim_dwn_pls_o;
  logic       cmd_uart_en_o;

  int checks = 0;
  int errors = 0;
  int n_valid, n_ferr, n_upd, n_up, n_dn, n_busy, n_misalign;

  always #5 clk = ~clk;

  uart_rx_cmd #(
    .BIT_CNT     (BIT),
    .SYNC_STAGES (2)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .rxd_i             (rxd),
    .clr_i             (clr),
    .data_o            (data_o),
    .data_valid_o      (data_valid_o),
    .frame_err_o       (frame_err_o),
    .busy_o            (busy_o),
    .cmd_sel_o         (cmd_sel_o),
    .cmd_sel_update_o  (cmd_sel_update_o),
    .cmd_dim_up_pls_o  (cmd_dim_up_pls_o),
    .cmd_dim_dwn_pls_o (cmd_dim_dwn_pls_o),
    .cmd_uart_en_o     (cmd_uart_en_o)
  );

  // Count pulse cycles on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    if (data_valid_o)      n_valid++;
    if (frame_err_o)       n_ferr++;
    if (cmd_sel_update_o)  n_upd++;
    if (cmd_dim_up_pls_o)  n_up++;
    if (cmd_dim_dwn_pls_o) n_dn++;
    if (busy_o)            n_busy++;
    if ((cmd_sel_update_o || cmd_dim_up_pls_o || cmd_dim_dwn_pls_o) && !data_valid_o) n_misalign++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    n_valid = 0; n_ferr = 0; n_upd = 0; n_up = 0; n_dn = 0; n_busy = 0;
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    rxd = 1'b0;
    hold(BIT);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      hold(BIT);
    end
    rxd = stop;
    hold(BIT);
  endtask

  initial begin
    logic [7:0] b;
    n_misalign = 0;
    clear_counts();
    rst_n = 1'b0;
    rxd   = 1'b1;
    clr   = 1'b0;
    hold(5);

    // Reset values while reset is held.
    check("rst_data",  32'(data_o), 32'h00);
    check("rst_valid", 32'(data_valid_o), 32'h0);
    check("rst_ferr",  32'(frame_err_o), 32'h0);
    check("rst_busy",  32'(busy_o), 32'h0);
    check("rst_sel",   32'(cmd_sel_o), 32'h0);
    check("rst_upd",   32'(cmd_sel_update_o), 32'h0);
    check("rst_en",    32'(cmd_uart_en_o), 32'h0);
    rst_n = 1'b1;
    hold(2 * BIT);

    // A plain byte gives one valid pulse and no frame error.
    clear_counts();
    send_frame(8'h55, 1'b1);
    hold(2 * BIT);
    check("b55_data",  32'(data_o), 32'h55);
    check("b55_valid", n_valid, 1);
    check("b55_ferr",  n_ferr, 0);
    check("b55_busy",  32'(busy_o), 32'h0);

    // Send "2" then "+" back-to-back.
    clear_counts();
    send_frame(8'h32, 1'b1);
    send_frame(8'h2B, 1'b1);
    hold(2 * BIT);
    check("b2b_sel",   32'(cmd_sel_o), 32'h2);
    check("b2b_upd",   n_upd, 1);
    check("b2b_up",    n_up, 1);
    check("b2b_valid", n_valid, 2);
    check("b2b_data",  32'(data_o), 32'h2B);

    // A low glitch shorter than half a bit is rejected at mid start bit.
    clear_counts();
    rxd = 1'b0;
    hold(4);
    rxd = 1'b1;
    hold(2 * BIT);
    check("glitch_valid", n_valid, 0);
    check("glitch_ferr",  n_ferr, 0);
    check("glitch_busy",  32'(busy_o), 32'h0);
    check("glitch_busy_short", 32'((n_busy > 0) && (n_busy < BIT)), 32'h1);

    // Send 0xA3 with a low stop bit, then hold the line low for 20 bit times.
    clear_counts();
    send_frame(8'hA3, 1'b0);
    hold(20 * BIT);
    check("brk_busy_held", 32'(busy_o), 32'h1);
    rxd = 1'b1;
    hold(2 * BIT);
    check("brk_ferr",  n_ferr, 1);
    check("brk_valid", n_valid, 0);
    check("brk_data",  32'(data_o), 32'h2B);
    check("brk_busy",  32'(busy_o), 32'h0);
    clear_counts();
    send_frame(8'h45, 1'b1);
    hold(2 * BIT);
    check("brk_next_en",    32'(cmd_uart_en_o), 32'h1);
    check("brk_next_data",  32'(data_o), 32'h45);
    check("brk_next_valid", n_valid, 1);

    // clr_i is raised mid bit 4 of "1" and kept high for the rest of that frame,
    // so the frame's tail bits cannot look like a new start edge.
    clear_counts();
    b = 8'h31;
    rxd = 1'b0;
    hold(BIT);
    for (int i = 0; i < 4; i++) begin
      rxd = b[i];
      hold(BIT);
    end
    rxd = b[4];
    hold(BIT / 2);
    clr = 1'b1;
    hold(2);
    check("clr_busy", 32'(busy_o), 32'h0);
    hold(BIT - BIT / 2 - 2);
    for (int i = 5; i < 8; i++) begin
      rxd = b[i];
      hold(BIT);
    end
    rxd = 1'b1;
    hold(BIT);
    clr = 1'b0;
    hold(2 * BIT);
    check("clr_valid", n_valid, 0);
    check("clr_upd",   n_upd, 0);
    check("clr_sel",   32'(cmd_sel_o), 32'h2);
    clear_counts();
    send_frame(8'h33, 1'b1);
    hold(2 * BIT);
    check("clr_next_sel", 32'(cmd_sel_o), 32'h3);
    check("clr_next_upd", n_upd, 1);

    // A whole frame sent while clr_i is held high is ignored.
    clear_counts();
    clr = 1'b1;
    send_frame(8'h31, 1'b1);
    hold(BIT);
    clr = 1'b0;
    hold(2 * BIT);
    check("clrhold_valid", n_valid, 0);
    check("clrhold_sel",   32'(cmd_sel_o), 32'h3);

    // Reset is asserted during the data bits of "d" and held until the frame ends.
    clear_counts();
    b = 8'h64;
    rxd = 1'b0;
    hold(BIT);
    for (int i = 0; i < 2; i++) begin
      rxd = b[i];
      hold(BIT);
    end
    rxd = b[2];
    hold(BIT / 2);
    rst_n = 1'b0;
    hold(2);
    check("mrst_data", 32'(data_o), 32'h00);
    check("mrst_sel",  32'(cmd_sel_o), 32'h0);
    check("mrst_en",   32'(cmd_uart_en_o), 32'h0);
    check("mrst_busy", 32'(busy_o), 32'h0);
    hold(BIT - BIT / 2 - 2);
    for (int i = 3; i < 8; i++) begin
      rxd = b[i];
      hold(BIT);
    end
    rxd = 1'b1;
    hold(BIT);
    rst_n = 1'b1;
    hold(2 * BIT);
    check("mrst_quiet", n_valid, 0);
    clear_counts();
    send_frame(8'h30, 1'b1);
    hold(2 * BIT);
    check("mrst_next_sel",   32'(cmd_sel_o), 32'h0);
    check("mrst_next_upd",   n_upd, 1);
    check("mrst_next_valid", n_valid, 1);
    check("mrst_next_data",  32'(data_o), 32'h30);

    // Send "e", "-", "D" and an ignored "Z".
    clear_counts();
    send_frame(8'h65, 1'b1);
    hold(BIT);
    check("cmd_e_en", 32'(cmd_uart_en_o), 32'h1);
    send_frame(8'h2D, 1'b1);
    hold(BIT);
    check("cmd_dn", n_dn, 1);
    send_frame(8'h44, 1'b1);
    hold(BIT);
    check("cmd_d_en", 32'(cmd_uart_en_o), 32'h0);
    send_frame(8'h5A, 1'b1);
    hold(2 * BIT);
    check("cmd_z_valid", n_valid, 4);
    check("cmd_z_data",  32'(data_o), 32'h5A);
    check("cmd_z_up",    n_up, 0);
    check("cmd_z_upd",   n_upd, 0);
    check("cmd_z_sel",   32'(cmd_sel_o), 32'h0);
    check("cmd_align",   n_misalign, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
